// File: rtl/dfr_output_reader.sv
// -----------------------------------------------------------------------------
// dfr_output_reader
//
// Purpose:
//   Reader side of the DFR output RAM. After a run, this block reads the stored
//   reservoir output words back in address order (0 .. len-1) and streams them
//   out over a valid/ready interface. Each word is sign-extended to 32 bits, the
//   final word is flagged with out_last, and done pulses for one cycle once the
//   stream has completed.
//
//   Effective length len = min(num_outputs, 2**ADDR_WIDTH), latched on an
//   accepted start. One word is produced every 3 cycles while out_ready is held
//   high (FETCH -> LOAD -> PRESENT).
//
// Parameters:
//   ADDR_WIDTH  output RAM address width, 1..31 (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  stored word width, 1..32
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   synchronous active-low reset
//   start        in   one-cycle readout request, honoured only when idle
//   num_outputs  in   requested word count, sampled on an accepted start
//   ram_raddr    out  registered RAM read address
//   ram_rdata    in   RAM read data, one clock after ram_raddr is sampled
//   out_valid    out  out_data/out_last valid
//   out_ready    in   downstream accepts when high together with out_valid
//   out_data     out  sign-extended output word
//   out_last     out  high with the final word of the stream
//   busy         out  readout in progress
//   done         out  one-cycle pulse at stream completion
// -----------------------------------------------------------------------------
module dfr_output_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 26
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [31:0]           num_outputs,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // Length needs one extra bit so that a full-depth stream (2**ADDR_WIDTH)
    // is representable.
    localparam int              LW    = ADDR_WIDTH + 1;
    localparam logic [32:0]     DEPTH = 33'd1 << ADDR_WIDTH;
    localparam logic [LW-1:0]   ONE   = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_PRESENT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t                  state_q;
    logic [LW-1:0]           len_q;
    logic [ADDR_WIDTH-1:0]   raddr_q;
    logic                    valid_q;
    logic [31:0]             data_q;
    logic                    last_q;
    logic                    busy_q;
    logic                    done_q;

    logic [LW-1:0]           len_d;
    logic [31:0]             ext_data;
    logic                    is_last;

    // Saturate the requested count at the RAM depth.
    always_comb begin
        len_d = num_outputs[LW-1:0];
        if ({1'b0, num_outputs} > DEPTH) begin
            len_d = DEPTH[LW-1:0];
        end
    end

    // Sign extension; a full 32-bit word needs no padding, and a zero-width
    // replication is not legal, so the two cases are split at elaboration.
    generate
        if (DATA_WIDTH == 32) begin : g_no_ext
            assign ext_data = ram_rdata;
        end else begin : g_ext
            assign ext_data = {{(32 - DATA_WIDTH){ram_rdata[DATA_WIDTH-1]}}, ram_rdata};
        end
    endgenerate

    // len_q >= 1 whenever this is consulted, so len_q - 1 cannot underflow.
    assign is_last = ({1'b0, raddr_q} == (len_q - ONE));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            raddr_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q <= len_d;
                        if (len_d != '0) begin
                            raddr_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end else begin
                            // Empty stream: no words, just the completion pulse.
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FETCH: begin
                    // RAM samples raddr_q on this edge; data arrives next cycle.
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    data_q  <= ext_data;
                    last_q  <= is_last;
                    valid_q <= 1'b1;
                    state_q <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            last_q  <= 1'b0;
                            state_q <= S_FIN;
                        end else begin
                            raddr_q <= raddr_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_raddr = raddr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dfr_output_reader.sv
// -----------------------------------------------------------------------------
// tb_dfr_output_reader
//
// Directed bench for dfr_output_reader. Two instances: the default geometry
// (ADDR_WIDTH=10) and a 4-deep one (ADDR_WIDTH=2) for length saturation.
// Each has a small synchronous-read RAM model. Inputs are driven and outputs
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_dfr_output_reader;

    logic        clock;
    logic        resetn;

    // Instance A (ADDR_WIDTH = 10)
    logic        start;
    logic [31:0] num_outputs;
    logic [9:0]  ram_raddr;
    logic [25:0] ram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    // Instance B (ADDR_WIDTH = 2)
    logic        start2;
    logic [31:0] num_outputs2;
    logic [1:0]  ram_raddr2;
    logic [25:0] ram_rdata2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_data2;
    logic        out_last2;
    logic        busy2;
    logic        done2;

    logic [25:0] mem  [0:1023];
    logic [25:0] mem2 [0:3];

    int tests;
    int failed;

    dfr_output_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(26)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .num_outputs (num_outputs),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    dfr_output_reader #(.ADDR_WIDTH(2), .DATA_WIDTH(26)) dut2 (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start2),
        .num_outputs (num_outputs2),
        .ram_raddr   (ram_raddr2),
        .ram_rdata   (ram_rdata2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_data    (out_data2),
        .out_last    (out_last2),
        .busy        (busy2),
        .done        (done2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM models.
    always @(posedge clock) begin
        ram_rdata  <= mem[ram_raddr];
        ram_rdata2 <= mem2[ram_raddr2];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Checks the complete output state of instance A in one call.
    task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic [9:0] a, input logic b, input logic dn);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".data"}, out_data, d);
            chk({tag, ".last"}, {31'd0, out_last}, {31'd0, l});
        end
        chk({tag, ".raddr"}, {22'd0, ram_raddr}, {22'd0, a});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        resetn       = 1'b0;
        start        = 1'b0;
        num_outputs  = 32'd0;
        out_ready    = 1'b1;
        start2       = 1'b0;
        num_outputs2 = 32'd0;
        out_ready2   = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 26'd0;
        mem[0] = 26'h0000001;
        mem[1] = 26'h3FFFFFF;
        mem[2] = 26'h2000000;
        mem2[0] = 26'h0000011;
        mem2[1] = 26'h0000022;
        mem2[2] = 26'h3FFFFFF;
        mem2[3] = 26'h2000001;

        // ---------------- Reset state ----------------
        tick();
        tick();
        chk("rst.data", out_data, 32'h0);
        chk("rst.last", {31'd0, out_last}, 32'd0);
        chk_a("rst", 1'b0, 32'h0, 1'b0, 10'd0, 1'b0, 1'b0);
        chk("rst2.valid", {31'd0, out_valid2}, 32'd0);
        chk("rst2.busy", {31'd0, busy2}, 32'd0);
        resetn = 1'b1;
        tick();

        // ---------------- Test 1: basic 3-word stream ----------------
        num_outputs = 32'd3;
        start       = 1'b1;
        tick();                                   // edge 1 samples start
        start       = 1'b0;
        chk_a("t1.e1", 1'b0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();                                   // edge 2
        chk_a("t1.e2", 1'b0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();                                   // edge 3: first word
        chk_a("t1.w0", 1'b1, 32'h00000001, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();                                   // handshake
        chk_a("t1.h0", 1'b0, 32'h0, 1'b0, 10'd1, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t1.w1", 1'b1, 32'hFFFFFFFF, 1'b0, 10'd1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_a("t1.w2", 1'b1, 32'hFE000000, 1'b1, 10'd2, 1'b1, 1'b0);
        tick();                                   // final handshake
        chk_a("t1.h2", 1'b0, 32'h0, 1'b0, 10'd2, 1'b1, 1'b0);
        chk("t1.h2.last", {31'd0, out_last}, 32'd0);
        tick();
        chk_a("t1.done", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b1);
        tick();
        chk_a("t1.idle", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b0);

        // ---------------- Test 2: backpressure on word 1 ----------------
        num_outputs = 32'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        tick();
        tick();
        chk_a("t2.w0", 1'b1, 32'h00000001, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_a("t2.w1", 1'b1, 32'hFFFFFFFF, 1'b0, 10'd1, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("t2.hold%0d", i), 1'b1, 32'hFFFFFFFF, 1'b0, 10'd1, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_a("t2.h1", 1'b0, 32'h0, 1'b0, 10'd2, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t2.w2", 1'b1, 32'hFE000000, 1'b1, 10'd2, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t2.done", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b1);
        tick();

        // ---------------- Test 3: zero-length stream ----------------
        num_outputs = 32'd0;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk_a("t3.e1", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b0);
        tick();
        chk_a("t3.done", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b1);
        tick();
        chk_a("t3.idle", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b0);

        // ---------------- Test 4: saturation on the 4-deep instance ----------------
        num_outputs2 = 32'hFFFFFFFF;
        start2       = 1'b1;
        tick();
        start2       = 1'b0;
        chk("t4.busy", {31'd0, busy2}, 32'd1);
        tick();
        tick();
        chk("t4.w0.valid", {31'd0, out_valid2}, 32'd1);
        chk("t4.w0.data", out_data2, 32'h00000011);
        chk("t4.w0.last", {31'd0, out_last2}, 32'd0);
        chk("t4.w0.addr", {30'd0, ram_raddr2}, 32'd0);
        tick();
        tick();
        tick();
        chk("t4.w1.valid", {31'd0, out_valid2}, 32'd1);
        chk("t4.w1.data", out_data2, 32'h00000022);
        chk("t4.w1.last", {31'd0, out_last2}, 32'd0);
        chk("t4.w1.addr", {30'd0, ram_raddr2}, 32'd1);
        tick();
        tick();
        tick();
        chk("t4.w2.valid", {31'd0, out_valid2}, 32'd1);
        chk("t4.w2.data", out_data2, 32'hFFFFFFFF);
        chk("t4.w2.last", {31'd0, out_last2}, 32'd0);
        chk("t4.w2.addr", {30'd0, ram_raddr2}, 32'd2);
        tick();
        tick();
        tick();
        chk("t4.w3.valid", {31'd0, out_valid2}, 32'd1);
        chk("t4.w3.data", out_data2, 32'hFE000001);
        chk("t4.w3.last", {31'd0, out_last2}, 32'd1);
        chk("t4.w3.addr", {30'd0, ram_raddr2}, 32'd3);
        tick();
        chk("t4.h3.valid", {31'd0, out_valid2}, 32'd0);
        chk("t4.h3.addr", {30'd0, ram_raddr2}, 32'd3);
        chk("t4.h3.done", {31'd0, done2}, 32'd0);
        tick();
        chk("t4.done", {31'd0, done2}, 32'd1);
        chk("t4.done.busy", {31'd0, busy2}, 32'd0);
        chk("t4.done.valid", {31'd0, out_valid2}, 32'd0);
        tick();
        chk("t4.idle.done", {31'd0, done2}, 32'd0);

        // ---------------- Test 5: start re-pulsed mid-stream and in FIN ----------------
        num_outputs = 32'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        tick();
        tick();
        chk_a("t5.w0", 1'b1, 32'h00000001, 1'b0, 10'd0, 1'b1, 1'b0);
        start       = 1'b1;                       // ignored: PRESENT
        num_outputs = 32'd1;
        tick();
        start       = 1'b0;
        chk_a("t5.h0", 1'b0, 32'h0, 1'b0, 10'd1, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t5.w1", 1'b1, 32'hFFFFFFFF, 1'b0, 10'd1, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_a("t5.w2", 1'b1, 32'hFE000000, 1'b1, 10'd2, 1'b1, 1'b0);
        tick();                                   // final handshake, now in FIN
        start       = 1'b1;                       // ignored: FIN
        num_outputs = 32'd2;
        tick();
        start       = 1'b0;
        chk_a("t5.done", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b1);
        tick();
        chk_a("t5.idle", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b0);
        tick();
        tick();
        chk_a("t5.still", 1'b0, 32'h0, 1'b0, 10'd2, 1'b0, 1'b0);

        // ---------------- Test 6: reset mid-stream, then restart ----------------
        num_outputs = 32'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk_a("t6.w1", 1'b1, 32'hFFFFFFFF, 1'b0, 10'd1, 1'b1, 1'b0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("t6.rst.data", out_data, 32'h0);
        chk("t6.rst.last", {31'd0, out_last}, 32'd0);
        chk_a("t6.rst", 1'b0, 32'h0, 1'b0, 10'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a($sformatf("t6.quiet%0d", i), 1'b0, 32'h0, 1'b0, 10'd0, 1'b0, 1'b0);
        end
        num_outputs = 32'd2;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk_a("t6.e1", 1'b0, 32'h0, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t6.w0", 1'b1, 32'h00000001, 1'b0, 10'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_a("t6.w1b", 1'b1, 32'hFFFFFFFF, 1'b1, 10'd1, 1'b1, 1'b0);
        tick();
        tick();
        chk_a("t6.done", 1'b0, 32'h0, 1'b0, 10'd1, 1'b0, 1'b1);
        tick();
        chk_a("t6.idle", 1'b0, 32'h0, 1'b0, 10'd1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
